// File: rtl/act_unroller_pkg.sv
// Shared helpers for the activation unroller: counter width derivation.
package act_unroller_pkg;

   // Width of a counter that must hold values 0..n-1; never narrower than one bit.
   function automatic int cnt_width(input int n);
      if (n <= 1) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

endpackage

// File: rtl/act_unroller.sv
// act_unroller: gathers RATIO consecutive narrow activation beats into one OUT_NUM-wide beat.
// Define ACT_UNROLLER_LAST_EN to add data_out_0_last and the per-tensor output-beat counter.
module act_unroller
   import act_unroller_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int IN_NUM      = 1,
   parameter int OUT_NUM     = 4,
   parameter int TENSOR_SIZE = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in_0 [IN_NUM],
   input  logic                  data_in_0_valid,
   output logic                  data_in_0_ready,
   output logic [DATA_WIDTH-1:0] data_out_0 [OUT_NUM],
   output logic                  data_out_0_valid,
   input  logic                  data_out_0_ready
`ifdef ACT_UNROLLER_LAST_EN
   ,
   output logic                  data_out_0_last
`endif
);

   localparam int RATIO = OUT_NUM / IN_NUM;
   localparam int CNT_W = cnt_width(RATIO);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATIO - 1);

   generate
      if ((OUT_NUM % IN_NUM) != 0) begin : g_bad_ratio
         $fatal(1, "act_unroller: OUT_NUM must be a multiple of IN_NUM");
      end
      if ((TENSOR_SIZE % OUT_NUM) != 0) begin : g_bad_tensor
         $fatal(1, "act_unroller: TENSOR_SIZE must be a multiple of OUT_NUM");
      end
   endgenerate

   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] col_q [OUT_NUM];
   logic [DATA_WIDTH-1:0] col_d [OUT_NUM];
   logic [DATA_WIDTH-1:0] out_q [OUT_NUM];
   logic [DATA_WIDTH-1:0] out_d [OUT_NUM];
   logic                  out_v_q, out_v_d;

   logic last_slot_s;
   logic accept_s;
   logic complete_s;
   logic drain_s;

   // Handshake decode: only the completing beat needs room in the output register.
   always_comb begin
      last_slot_s     = (cnt_q == CNT_MAX);
      data_in_0_ready = !last_slot_s || !out_v_q || data_out_0_ready;
      accept_s        = data_in_0_valid && data_in_0_ready;
      complete_s      = accept_s && last_slot_s;
      drain_s         = out_v_q && data_out_0_ready;
   end

   // Next-state: fill the collect slice selected by cnt, hand full words to the output register.
   always_comb begin
      cnt_d   = cnt_q;
      col_d   = col_q;
      out_d   = out_q;
      out_v_d = out_v_q;

      for (int k = 0; k < RATIO; k++) begin
         for (int j = 0; j < IN_NUM; j++) begin
            if (accept_s && (cnt_q == CNT_W'(k))) begin
               col_d[k*IN_NUM + j] = data_in_0[j];
            end else begin
               col_d[k*IN_NUM + j] = col_q[k*IN_NUM + j];
            end
         end
      end

      if (accept_s) begin
         if (last_slot_s) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         cnt_d = cnt_q;
      end

      // A load in the same cycle as a drain keeps valid high, so there is no bubble.
      if (complete_s) begin
         out_d   = col_d;
         out_v_d = 1'b1;
      end else if (drain_s) begin
         out_v_d = 1'b0;
      end else begin
         out_v_d = out_v_q;
      end
   end

   // State registers; reset discards any partial collection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q   <= '0;
         out_v_q <= 1'b0;
         for (int i = 0; i < OUT_NUM; i++) begin
            col_q[i] <= '0;
            out_q[i] <= '0;
         end
      end else begin
         cnt_q   <= cnt_d;
         out_v_q <= out_v_d;
         col_q   <= col_d;
         out_q   <= out_d;
      end
   end

   assign data_out_0       = out_q;
   assign data_out_0_valid = out_v_q;

`ifdef ACT_UNROLLER_LAST_EN
   localparam int OBEATS  = TENSOR_SIZE / OUT_NUM;
   localparam int OBEAT_W = cnt_width(OBEATS);
   localparam logic [OBEAT_W-1:0] OBEAT_MAX = OBEAT_W'(OBEATS - 1);

   logic [OBEAT_W-1:0] obeat_q, obeat_d;

   // Output-beat position within the tensor, advanced on each output handshake.
   always_comb begin
      obeat_d = obeat_q;
      if (drain_s) begin
         if (obeat_q == OBEAT_MAX) begin
            obeat_d = '0;
         end else begin
            obeat_d = obeat_q + 1'b1;
         end
      end else begin
         obeat_d = obeat_q;
      end
   end

   // Output-beat counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         obeat_q <= '0;
      end else begin
         obeat_q <= obeat_d;
      end
   end

   assign data_out_0_last = out_v_q && (obeat_q == OBEAT_MAX);
`endif

endmodule

// File: tb/tb_act_unroller.sv
// Scoreboard bench for act_unroller: three instances cover RATIO=4 (IN_NUM=1), RATIO=2 and RATIO=1.
module tb_act_unroller;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Instance A: IN_NUM=1, OUT_NUM=4, TENSOR_SIZE=8
   logic [7:0] a_in [1];
   logic       a_iv = 1'b0, a_ir, a_ov, a_ordy = 1'b1, a_last;
   logic [7:0] a_out [4];
   // Instance B: IN_NUM=2, OUT_NUM=4
   logic [7:0] b_in [2];
   logic       b_iv = 1'b0, b_ir, b_ov, b_ordy = 1'b1, b_last;
   logic [7:0] b_out [4];
   // Instance C: IN_NUM=2, OUT_NUM=2 (register slice)
   logic [7:0] c_in [2];
   logic       c_iv = 1'b0, c_ir, c_ov, c_ordy = 1'b1, c_last;
   logic [7:0] c_out [2];

   act_unroller #(.DATA_WIDTH(8), .IN_NUM(1), .OUT_NUM(4), .TENSOR_SIZE(8)) u_a (
      .clk(clk), .rst(rst),
      .data_in_0(a_in), .data_in_0_valid(a_iv), .data_in_0_ready(a_ir),
      .data_out_0(a_out), .data_out_0_valid(a_ov), .data_out_0_ready(a_ordy)
`ifdef ACT_UNROLLER_LAST_EN
      , .data_out_0_last(a_last)
`endif
   );

   act_unroller #(.DATA_WIDTH(8), .IN_NUM(2), .OUT_NUM(4), .TENSOR_SIZE(16)) u_b (
      .clk(clk), .rst(rst),
      .data_in_0(b_in), .data_in_0_valid(b_iv), .data_in_0_ready(b_ir),
      .data_out_0(b_out), .data_out_0_valid(b_ov), .data_out_0_ready(b_ordy)
`ifdef ACT_UNROLLER_LAST_EN
      , .data_out_0_last(b_last)
`endif
   );

   act_unroller #(.DATA_WIDTH(8), .IN_NUM(2), .OUT_NUM(2), .TENSOR_SIZE(16)) u_c (
      .clk(clk), .rst(rst),
      .data_in_0(c_in), .data_in_0_valid(c_iv), .data_in_0_ready(c_ir),
      .data_out_0(c_out), .data_out_0_valid(c_ov), .data_out_0_ready(c_ordy)
`ifdef ACT_UNROLLER_LAST_EN
      , .data_out_0_last(c_last)
`endif
   );

`ifndef ACT_UNROLLER_LAST_EN
   assign a_last = 1'b0;
   assign b_last = 1'b0;
   assign c_last = 1'b0;
`endif

   typedef struct packed {
      logic        last;
      logic [31:0] data;
   } exp_a_t;

   exp_a_t      q_a [$];
   logic [31:0] q_b [$];
   logic [15:0] q_c [$];
   bit          chk_last = 1'b0;
   int          a_stall = 0;
   int          b_stall = 0;

   function automatic logic [31:0] pack4(input logic [7:0] d [4]);
      return {d[3], d[2], d[1], d[0]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one beat into A and hold it until accepted (bounded).
   task automatic send_a(input logic [7:0] v);
      int n;
      n = 0;
      a_in[0] = v;
      a_iv    = 1'b1;
      forever begin
         @(negedge clk);
         if (a_ir) begin
            tick();
            break;
         end
         a_stall++;
         tick();
         n++;
         if (n > 200) begin
            chk("a_send_timeout", 64'd1, 64'd0);
            break;
         end
      end
      a_iv = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] v0, input logic [7:0] v1);
      int n;
      n = 0;
      b_in[0] = v0;
      b_in[1] = v1;
      b_iv    = 1'b1;
      forever begin
         @(negedge clk);
         if (b_ir) begin
            tick();
            break;
         end
         b_stall++;
         tick();
         n++;
         if (n > 200) begin
            chk("b_send_timeout", 64'd1, 64'd0);
            break;
         end
      end
      b_iv = 1'b0;
   endtask

   // Monitor A: pop and compare on every output handshake.
   exp_a_t ea;
   always @(negedge clk) begin
      if (rst && a_ov && a_ordy) begin
         if (q_a.size() == 0) begin
            chk("a_unexpected_beat", 64'(pack4(a_out)), 64'hDEAD_0000_0000_0000);
         end else begin
            ea = q_a.pop_front();
            chk("a_data", 64'(pack4(a_out)), 64'(ea.data));
            if (chk_last) chk("a_last", 64'(a_last), 64'(ea.last));
         end
      end
   end

   // Monitor B.
   logic [31:0] eb;
   always @(negedge clk) begin
      if (rst && b_ov && b_ordy) begin
         if (q_b.size() == 0) begin
            chk("b_unexpected_beat", 64'(pack4(b_out)), 64'hDEAD_0000_0000_0000);
         end else begin
            eb = q_b.pop_front();
            chk("b_data", 64'(pack4(b_out)), 64'(eb));
         end
      end
   end

   // Monitor C.
   logic [15:0] ec;
   always @(negedge clk) begin
      if (rst && c_ov && c_ordy) begin
         if (q_c.size() == 0) begin
            chk("c_unexpected_beat", 64'({c_out[1], c_out[0]}), 64'hDEAD_0000_0000_0000);
         end else begin
            ec = q_c.pop_front();
            chk("c_data", 64'({c_out[1], c_out[0]}), 64'(ec));
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_chk);
      $fatal(1, "watchdog");
   end

   logic [31:0] stream_words [4];
   int          c_seq;
   bit          m_ov;
   bit          c_acc;

   initial begin
      a_in[0] = 8'h00;
      b_in[0] = 8'h00; b_in[1] = 8'h00;
      c_in[0] = 8'h00; c_in[1] = 8'h00;
      stream_words[0] = 32'h0302_0100;
      stream_words[1] = 32'h0706_0504;
      stream_words[2] = 32'h0B0A_0908;
      stream_words[3] = 32'h0F0E_0D0C;

      // Reset state
      #12;
      chk("rst_a_valid", 64'(a_ov), 64'd0);
      chk("rst_a_ready", 64'(a_ir), 64'd1);
      chk("rst_a_data",  64'(pack4(a_out)), 64'd0);
      chk("rst_b_valid", 64'(b_ov), 64'd0);
      chk("rst_c_valid", 64'(c_ov), 64'd0);
      chk("rst_c_data",  64'({c_out[1], c_out[0]}), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // Packing order on A
      a_ordy = 1'b1;
      send_a(8'h11);
      send_a(8'h22);
      send_a(8'h33);
      chk("pack_valid_early", 64'(a_ov), 64'd0);
      q_a.push_back('{last: 1'b0, data: 32'h4433_2211});
      send_a(8'h44);
      chk("pack_latency", 64'(a_ov), 64'd1);
      tick();

      // Streaming on B
      b_stall = 0;
      for (int i = 0; i < 8; i++) begin
         if ((i % 2) == 1) q_b.push_back(stream_words[i/2]);
         send_b(8'(2*i), 8'(2*i + 1));
      end
      chk("stream_no_stall", 64'(b_stall), 64'd0);
      repeat (3) tick();

      // Backpressure on A
      a_ordy = 1'b0;
      send_a(8'hA1);
      send_a(8'hA2);
      send_a(8'hA3);
      q_a.push_back('{last: 1'b0, data: 32'hA4A3_A2A1});
      send_a(8'hA4);
      a_stall = 0;
      send_a(8'hA5);
      send_a(8'hA6);
      send_a(8'hA7);
      chk("bp_partial_accept", 64'(a_stall), 64'd0);
      a_in[0] = 8'hA8;
      a_iv    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_ready_low", 64'(a_ir), 64'd0);
         chk("bp_valid_hold", 64'(a_ov), 64'd1);
         chk("bp_data_hold", 64'(pack4(a_out)), 64'hA4A3_A2A1);
         tick();
      end
      q_a.push_back('{last: 1'b0, data: 32'hA8A7_A6A5});
      a_ordy = 1'b1;
      @(negedge clk);
      chk("bp_ready_release", 64'(a_ir), 64'd1);
      tick();
      a_iv = 1'b0;
      chk("bp_no_bubble", 64'(a_ov), 64'd1);
      chk("bp_new_word", 64'(pack4(a_out)), 64'hA8A7_A6A5);
      repeat (3) tick();

      // RATIO=1 on C with random valid/ready
      c_seq = 0;
      m_ov  = 1'b0;
      c_iv  = 1'b0;
      for (int i = 0; i < 80; i++) begin
         if (!c_iv) begin
            c_iv    = ($urandom_range(0, 3) != 0);
            c_in[0] = 8'(2*c_seq);
            c_in[1] = 8'(2*c_seq + 1);
         end
         c_ordy = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         chk("c_ready", 64'(c_ir), 64'(!m_ov || c_ordy));
         chk("c_valid_latency", 64'(c_ov), 64'(m_ov));
         c_acc = c_iv && c_ir;
         if (c_acc) begin
            q_c.push_back({c_in[1], c_in[0]});
            c_seq++;
         end
         tick();
         m_ov = c_acc ? 1'b1 : (c_ordy ? 1'b0 : m_ov);
         if (c_acc) c_iv = 1'b0;
      end
      c_iv   = 1'b0;
      c_ordy = 1'b1;
      repeat (3) tick();
      chk("c_drained", 64'(q_c.size()), 64'd0);

      // Reset mid-tensor on A (output also pending)
      a_ordy = 1'b0;
      send_a(8'hC1);
      send_a(8'hC2);
      send_a(8'hC3);
      send_a(8'hC4);
      send_a(8'h55);
      send_a(8'h66);
      chk("rst_pre_valid", 64'(a_ov), 64'd1);
      rst = 1'b0;
      #1;
      chk("rst_mid_valid", 64'(a_ov), 64'd0);
      chk("rst_mid_data",  64'(pack4(a_out)), 64'd0);
      chk("rst_mid_ready", 64'(a_ir), 64'd1);
      #2;
      rst = 1'b1;
      tick();
      a_ordy = 1'b1;
      send_a(8'h71);
      send_a(8'h72);
      send_a(8'h73);
      chk("rst_clean_no_early", 64'(a_ov), 64'd0);
      q_a.push_back('{last: 1'b0, data: 32'h7473_7271});
      send_a(8'h74);
      chk("rst_clean_valid", 64'(a_ov), 64'd1);
      repeat (3) tick();

      // Three tensors of 8 elements on A; last on output beats 2, 4, 6
      rst = 1'b0;
      #2;
      rst = 1'b1;
      tick();
`ifdef ACT_UNROLLER_LAST_EN
      chk_last = 1'b1;
`endif
      for (int n = 0; n < 6; n++) begin
         for (int b = 0; b < 4; b++) begin
            if (b == 3) begin
               q_a.push_back('{last: ((n % 2) == 1),
                               data: {8'(4*n + 3), 8'(4*n + 2), 8'(4*n + 1), 8'(4*n)}});
            end
            send_a(8'(4*n + b));
         end
      end
      repeat (4) tick();
      chk_last = 1'b0;

      chk("a_queue_empty", 64'(q_a.size()), 64'd0);
      chk("b_queue_empty", 64'(q_b.size()), 64'd0);
      chk("c_queue_empty", 64'(q_c.size()), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
